// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and count sizing for the multiply/divide sequencer
package mdu_pkg;
  localparam int MDU_W  = 32;
  localparam int MDU_CW = $clog2(MDU_W);
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  function automatic int mdu_cw(int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: EX-stage issue/stall/result bundle between the pipeline and the mul/div sequencer
interface mdu_sequencer_if import mdu_pkg::*; #(parameter int WIDTH = MDU_W);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mf_req;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, rs_val, rt_val, mf_req, flush,
                  input  busy, stall, done, dz, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, mf_req, flush,
                  output busy, stall, done, dz, hi, lo);
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one shift-add (mul) or restoring shift-subtract (div) iteration on {acc,low}
// The divide path and its select input exist only when MDU_DIV_EN is defined.
module mdu_step import mdu_pkg::*; #(parameter int WIDTH = MDU_W) (
`ifdef MDU_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] low,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] low_o
);
  logic [WIDTH:0] sum;
`ifdef MDU_DIV_EN
  logic [WIDTH:0] sh, dif;
`endif
  always_comb begin
    sum = {1'b0, acc} + (low[0] ? {1'b0, m} : '0);
    {acc_o, low_o} = {sum, low[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    sh  = {acc, low[WIDTH-1]};
    dif = sh - {1'b0, m};
    if (div) {acc_o, low_o} = dif[WIDTH] ? {sh[WIDTH-1:0], low[WIDTH-2:0], 1'b0}
                                         : {dif[WIDTH-1:0], low[WIDTH-2:0], 1'b1};
`endif
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO and the EX stall request
// Divide is built only with MDU_DIV_EN; otherwise DIV/DIVU complete in one cycle leaving HI/LO untouched.
module mdu_sequencer import mdu_pkg::*; #(parameter int WIDTH = MDU_W) (
  input logic            clk,
  input logic            rst_n,
  mdu_sequencer_if.slave bus
);
  localparam int CW = mdu_cw(WIDTH);
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] acc_s, low_s, ra, rb, qf, rf;
  logic [2*WIDTH-1:0] mag, prod;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic ng_q, ng_d, ngr_q, ngr_d, dz_q, dz_d, done_q, done_d;
  logic sgn, skip, dv;
  mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
    .div(dv),
`endif
    .acc(acc_q), .low(low_q), .m(m_q), .acc_o(acc_s), .low_o(low_s));
  assign bus.busy  = state_q != IDLE;
  assign bus.stall = bus.busy && (bus.mf_req || bus.start);
  assign bus.done  = done_q;
  assign bus.dz    = dz_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  always_comb begin
    sgn   = ~bus.op[0];
    skip  = !DIV_EN && bus.op[1];
    dv    = DIV_EN && op_q[1];
    ra    = (sgn && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    rb    = (sgn && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    mag   = {acc_q, low_q};
    prod  = ng_q ? -mag : mag;
    qf    = ng_q ? -low_q : low_q;
    rf    = ngr_q ? -acc_q : acc_q;
    state_d = state_q;
    acc_d   = acc_q;
    low_d   = low_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ng_d    = ng_q;
    ngr_d   = ngr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    if (state_q == IDLE && bus.start && !bus.flush) begin
      state_d = skip ? IDLE : RUN;
      done_d  = skip;
      dz_d    = DIV_EN && bus.op[1] && bus.rt_val == '0;
      acc_d   = '0;
      cnt_d   = '0;
      op_d    = bus.op;
      low_d   = bus.op[1] ? ra : rb;
      m_d     = bus.op[1] ? rb : ra;
      ng_d    = sgn && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
      ngr_d   = sgn && bus.rs_val[WIDTH-1];
    end else if (state_q == RUN) begin
      state_d = bus.flush ? IDLE : (cnt_q == CW'(WIDTH-1) ? FIX : RUN);
      acc_d   = acc_s;
      low_d   = low_s;
      cnt_d   = cnt_q + CW'(1);
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d  = !bus.flush;
      hi_d    = bus.flush ? hi_q : (dv ? rf : prod[2*WIDTH-1:WIDTH]);
      lo_d    = bus.flush ? lo_q : (dv ? qf : prod[WIDTH-1:0]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      low_q   <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      ng_q    <= 1'b0;
      ngr_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ng_q    <= ng_d;
      ngr_q   <= ngr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end
endmodule
